// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One operand bit is consumed per clock; the result and an overflow flag are
// published together with a single-cycle done pulse.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state, state_next;

  logic [DW-1:0]    digits;
  logic [WIDTH-1:0] operand;
  logic [CW-1:0]    cnt;
  logic             ovf_int;

  logic [DW-1:0]    adj;
  logic [DW-1:0]    digits_shift;
  logic [WIDTH-1:0] operand_shift;
  logic             carry_out;
  logic             accept;
  logic             last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == SHIFT) && (cnt == CW'(1));
  assign busy      = (state == SHIFT);

  // One double-dabble step: add 3 to every digit >= 5, then shift the whole
  // {digits, operand} chain left; the bit leaving the top digit is overflow.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    adj = digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (digits[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = digits[4*k +: 4] + 4'd3;
      end
    end
    {carry_out, digits_shift, operand_shift} = {adj, operand, 1'b0};
  end

  // Next-state logic: leave IDLE on start, return after the last shift.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Working registers: load on accept, advance one step per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits  <= '0;
      operand <= '0;
      cnt     <= '0;
      ovf_int <= 1'b0;
    end else if (accept) begin
      digits  <= '0;
      operand <= bin;
      cnt     <= CW'(WIDTH);
      ovf_int <= 1'b0;
    end else if (state == SHIFT) begin
      digits  <= digits_shift;
      operand <= operand_shift;
      cnt     <= cnt - CW'(1);
      ovf_int <= ovf_int | carry_out;
    end
  end

  // Published outputs: updated only on the final step, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= last_step;
      if (last_step) begin
        bcd      <= digits_shift;
        overflow <= ovf_int | carry_out;
      end
    end
  end

endmodule
